// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types for the RV32I hazard / forwarding controller.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int unsigned SLOT_RW = 5;

    localparam logic [SLOT_RW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic               valid;
        logic [SLOT_RW-1:0] rs1;
        logic [SLOT_RW-1:0] rs2;
        logic [SLOT_RW-1:0] rd;
        logic               reg_write;
        logic               mem_read;
    } stage_slot_t;

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Brief    : Chooses the EX operand source for one register index (MEM > WB > RF).
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select
    import hazard_pkg::*;
(
    input  logic               ex_valid,
    input  logic [SLOT_RW-1:0] src,
    input  logic               mem_valid,
    input  logic               mem_reg_write,
    input  logic [SLOT_RW-1:0] mem_rd,
    input  logic               wb_valid,
    input  logic               wb_reg_write,
    input  logic [SLOT_RW-1:0] wb_rd,
    output fwd_sel_e           sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_valid) begin
            // MEM holds the younger result, so it is checked first
            if (mem_valid && mem_reg_write && (mem_rd != REG_ZERO) && (mem_rd == src)) begin
                sel = FWD_MEM;
            end else if (wb_valid && wb_reg_write && (wb_rd != REG_ZERO) && (wb_rd == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_fwd_ctrl
// Brief    : Stall/flush/forwarding control for the 5-stage RV32I pipeline.
//            Optional perf counters enabled by macro HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
`ifdef HAZARD_PERF_CNT_EN
   ,parameter int CNT_W      = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_stall,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  flush_id,
    output logic                  flush_ex
`ifdef HAZARD_PERF_CNT_EN
   ,output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    stage_slot_t r_ex;
    stage_slot_t r_mem;
    stage_slot_t r_wb;
    logic        w_lu;
    fwd_sel_e    w_fwd_a;
    fwd_sel_e    w_fwd_b;
    logic        w_unused;

    assign w_lu = id_valid && r_ex.valid && r_ex.mem_read && r_ex.reg_write &&
                  (r_ex.rd != REG_ZERO) && ((r_ex.rd == id_rs1) || (r_ex.rd == id_rs2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!mem_stall) begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
            // Branch and load-use both inject a bubble into EX
            if (ex_branch_taken || w_lu) begin
                r_ex <= '0;
            end else begin
                r_ex.valid     <= id_valid;
                r_ex.rs1       <= id_rs1;
                r_ex.rs2       <= id_rs2;
                r_ex.rd        <= id_rd;
                r_ex.reg_write <= id_reg_write;
                r_ex.mem_read  <= id_mem_read;
            end
        end
    end

    // Gated by rst_n so the controls drop the moment reset asserts
    always_comb begin
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        if (rst_n) begin
            if (mem_stall) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (ex_branch_taken) begin
                flush_id = 1'b1;
                flush_ex = 1'b1;
            end else if (w_lu) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                flush_ex = 1'b1;
            end
        end
    end

    fwd_select u_fwd_a (
        .ex_valid      (r_ex.valid),
        .src           (r_ex.rs1),
        .mem_valid     (r_mem.valid),
        .mem_reg_write (r_mem.reg_write),
        .mem_rd        (r_mem.rd),
        .wb_valid      (r_wb.valid),
        .wb_reg_write  (r_wb.reg_write),
        .wb_rd         (r_wb.rd),
        .sel           (w_fwd_a)
    );

    fwd_select u_fwd_b (
        .ex_valid      (r_ex.valid),
        .src           (r_ex.rs2),
        .mem_valid     (r_mem.valid),
        .mem_reg_write (r_mem.reg_write),
        .mem_rd        (r_mem.rd),
        .wb_valid      (r_wb.valid),
        .wb_reg_write  (r_wb.reg_write),
        .wb_rd         (r_wb.rd),
        .sel           (w_fwd_b)
    );

    assign fwd_a_sel = w_fwd_a;
    assign fwd_b_sel = w_fwd_b;

    assign w_unused = ^{r_mem.rs1, r_mem.rs2, r_mem.mem_read,
                        r_wb.rs1, r_wb.rs2, r_wb.mem_read};

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!mem_stall) begin
            if (w_lu && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ex_branch_taken && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_fwd_ctrl
// Brief    : Directed self-checking bench for hazard_fwd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_reg_write, id_mem_read;
    logic       ex_branch_taken, mem_stall;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall_if, stall_id, flush_id, flush_ex;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.REG_ADDR_W(5)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .flush_ex        (flush_ex)
`ifdef HAZARD_PERF_CNT_EN
       ,.stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic we, input logic mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_reg_write = we; id_mem_read = mr;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ex_branch_taken = 1'b0;
        mem_stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        mem_stall = 1'b1;
        ex_branch_taken = 1'b1;
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
        total++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin bad++; $display("FAIL reset_ctl: got %b want 0000", {stall_if, stall_id, flush_id, flush_ex}); end
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL reset_fwd: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
        mem_stall = 1'b0;
        ex_branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        do_reset();
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);             // add x5,x1,x2
        tick();
        set_id(1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0);             // sub x6,x5,x1
        total++; if ({stall_if, stall_id, flush_ex} !== 3'b000) begin bad++; $display("FAIL b2b_nostall: got %b want 000", {stall_if, stall_id, flush_ex}); end
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        total++; if (fwd_a_sel !== 2'b10) begin bad++; $display("FAIL b2b_fwd_a: got %b want 10", fwd_a_sel); end
        total++; if (fwd_b_sel !== 2'b00) begin bad++; $display("FAIL b2b_fwd_b: got %b want 00", fwd_b_sel); end
        drain();
    endtask

    task automatic test_wb_fwd();
        set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);             // add x7
        tick();
        set_id(1'b1, 5'd11, 5'd12, 5'd10, 1'b1, 1'b0);          // unrelated
        tick();
        set_id(1'b1, 5'd3, 5'd7, 5'd13, 1'b1, 1'b0);            // uses x7 as rs2
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        total++; if (fwd_b_sel !== 2'b01) begin bad++; $display("FAIL wb_fwd_b: got %b want 01", fwd_b_sel); end
        total++; if (fwd_a_sel !== 2'b00) begin bad++; $display("FAIL wb_fwd_a: got %b want 00", fwd_a_sel); end
        drain();
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1);             // lw x8
        tick();
        set_id(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0);             // add x9,x8,x8
        total++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b1101) begin bad++; $display("FAIL lu_stall: got %b want 1101", {stall_if, stall_id, flush_id, flush_ex}); end
        tick();
        set_id(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0);             // held in ID
        total++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin bad++; $display("FAIL lu_one_cycle: got %b want 0000", {stall_if, stall_id, flush_id, flush_ex}); end
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0101) begin bad++; $display("FAIL lu_fwd: got %b want 0101", {fwd_a_sel, fwd_b_sel}); end
        drain();
    endtask

    task automatic test_branch_over_lu();
        set_id(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1);             // lw x8
        tick();
        set_id(1'b1, 5'd8, 5'd1, 5'd9, 1'b1, 1'b0);
        ex_branch_taken = 1'b1;
        #1;
        total++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0011) begin bad++; $display("FAIL br_lu: got %b want 0011", {stall_if, stall_id, flush_id, flush_ex}); end
        tick();
        ex_branch_taken = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        total++; if ({stall_if, flush_ex, fwd_a_sel} !== 4'b0000) begin bad++; $display("FAIL br_after: got %b want 0000", {stall_if, flush_ex, fwd_a_sel}); end
        drain();
    endtask

    task automatic test_x0_mem_stall();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);             // write x5
        tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);             // write x0
        tick();
        set_id(1'b1, 5'd0, 5'd5, 5'd14, 1'b1, 1'b0);            // use x0, x5
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin bad++; $display("FAIL x0_fwd: got %b want 0001", {fwd_a_sel, fwd_b_sel}); end
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ex_branch_taken = (i == 1);
            #1;
            total++; if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b1100) begin bad++; $display("FAIL mstall_ctl[%0d]: got %b want 1100", i, {stall_if, stall_id, flush_id, flush_ex}); end
            total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0001) begin bad++; $display("FAIL mstall_fwd[%0d]: got %b want 0001", i, {fwd_a_sel, fwd_b_sel}); end
            tick();
        end
        mem_stall = 1'b0;
        ex_branch_taken = 1'b0;
        #1;
        total++; if ({fwd_a_sel, fwd_b_sel, stall_if} !== 5'b00010) begin bad++; $display("FAIL mstall_after: got %b want 00010", {fwd_a_sel, fwd_b_sel, stall_if}); end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0);
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mem_stall = 1'b1;
        #1;
        total++; if ({stall_if, fwd_a_sel, fwd_b_sel} !== 5'b11010) begin bad++; $display("FAIL prereset: got %b want 11010", {stall_if, fwd_a_sel, fwd_b_sel}); end
        rst_n = 1'b0;
        #1;
        total++; if ({stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel} !== 8'h00) begin bad++; $display("FAIL async_reset: got %b want 00000000", {stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel}); end
        mem_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin bad++; $display("FAIL post_reset_slots: got %b want 0000", {fwd_a_sel, fwd_b_sel}); end
        drain();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        do_reset();
        total++; if ({stall_cnt, flush_cnt} !== 64'd0) begin bad++; $display("FAIL cnt_reset: got %0h want 0", {stall_cnt, flush_cnt}); end
        for (int k = 0; k < 2; k++) begin
            set_id(1'b1, 5'd2, 5'd0, 5'd8, 1'b1, 1'b1);
            tick();
            set_id(1'b1, 5'd1, 5'd8, 5'd9, 1'b1, 1'b0);
            tick();
            tick();
            drain();
        end
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        drain();
        total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL stall_cnt: got %0d want 2", stall_cnt); end
        total++; if (flush_cnt !== 32'd1) begin bad++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        ex_branch_taken = 1'b0;
        mem_stall = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #10;
        test_reset();
        test_back_to_back();
        test_wb_fwd();
        test_load_use();
        test_branch_over_lu();
        test_x0_mem_stall();
        test_reset_mid_stall();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
